// File: rtl/pipelined_prefix_adder_if.sv
// Operand/result handshake bundle for the pipelined prefix adder.
// The master side supplies operands and takes results, the slave side is the adder.
`timescale 1ns/1ps
interface pipelined_prefix_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf
    );
endinterface

// File: rtl/pipelined_prefix_adder.sv
// Kogge-Stone adder/subtractor with one register rank per prefix level.
// Rank 0 holds bit generate/propagate, ranks 1..LEVELS hold the prefix levels,
// and a final rank holds sum/cout/ovf. A single global stall freezes every rank.
`timescale 1ns/1ps
module pipelined_prefix_adder #(
    parameter int WIDTH = 16
) (
    input logic                     clk,
    input logic                     rst,
    pipelined_prefix_adder_if.slave bus
);
    localparam int LEVELS = $clog2(WIDTH);

    logic                          stall;
    logic [WIDTH-1:0]              b_eff;
    logic                          cin_eff;

    // Index 0 is the operand stage; index k+1 is the output of prefix level k.
    logic [LEVELS:0][WIDTH-1:0]    g_d;
    logic [LEVELS:0][WIDTH-1:0]    pg_d;
    logic [LEVELS:0][WIDTH-1:0]    g_q;
    logic [LEVELS:0][WIDTH-1:0]    pg_q;
    logic [LEVELS:0][WIDTH-1:0]    p_q;
    logic [LEVELS:0]               cin_q;
    logic [LEVELS:0]               v_q;

    logic [WIDTH-1:0]              carry;
    logic [WIDTH-1:0]              sum_d;
    logic                          cout_d;
    logic                          ovf_d;
    logic [WIDTH-1:0]              sum_q;
    logic                          cout_q;
    logic                          ovf_q;
    logic                          out_valid_q;

    // Group propagate of a node whose span already reaches the carry-in is
    // never consumed again; it is kept only so every level looks alike.
    logic                          unused_pg;
    assign unused_pg = ^pg_q;

    assign stall        = out_valid_q & ~bus.out_ready;
    assign bus.in_ready = ~stall & ~rst;

    assign b_eff   = bus.in_sub ? ~bus.in_b : bus.in_b;
    assign cin_eff = bus.in_cin ^ bus.in_sub;

    // Carry-in enters as the generate of a virtual bit -1 merged into bit 0.
    assign pg_d[0] = bus.in_a ^ b_eff;
    assign g_d[0]  = (bus.in_a & b_eff) | {{(WIDTH-1){1'b0}}, pg_d[0][0] & cin_eff};

    // Prefix level k merges node i with node i-2^k; lower nodes are already
    // complete carries and pass straight through.
    for (genvar k = 0; k < LEVELS; k++) begin : g_level
        for (genvar i = 0; i < WIDTH; i++) begin : g_node
            if (i >= (1 << k)) begin : g_merge
                assign g_d[k+1][i]  = g_q[k][i] | (pg_q[k][i] & g_q[k][i-(1<<k)]);
                assign pg_d[k+1][i] = pg_q[k][i] & pg_q[k][i-(1<<k)];
            end else begin : g_pass
                assign g_d[k+1][i]  = g_q[k][i];
                assign pg_d[k+1][i] = pg_q[k][i];
            end
        end
    end

    // After the last level every node is the carry out of its bit.
    assign carry  = g_q[LEVELS];
    assign sum_d  = p_q[LEVELS] ^ {carry[WIDTH-2:0], cin_q[LEVELS]};
    assign cout_d = carry[WIDTH-1];
    assign ovf_d  = carry[WIDTH-1] ^ carry[WIDTH-2];

    // Valid bits: cleared by reset, shift one rank per unstalled cycle.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every rank
        // samples the pre-edge value of the rank before it.
        if (rst) begin
            v_q         <= '0;
            out_valid_q <= 1'b0;
        end else if (!stall) begin
            v_q         <= {v_q[LEVELS-1:0], bus.in_valid};
            out_valid_q <= v_q[LEVELS];
        end
    end

    // Prefix datapath ranks: advance with the valids, hold on stall.
    always_ff @(posedge clk) begin
        // NOTE: these ranks are qualified by their valid bits, so they carry no
        // reset; clearing them would only add reset fan-out.
        if (!stall) begin
            g_q   <= g_d;
            pg_q  <= pg_d;
            p_q   <= {p_q[LEVELS-1:0], pg_d[0]};
            cin_q <= {cin_q[LEVELS-1:0], cin_eff};
        end
    end

    // Result rank: visible outputs, cleared by reset, frozen while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (!stall) begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = sum_q;
    assign bus.out_cout  = cout_q;
    assign bus.out_ovf   = ovf_q;
endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Self-checking bench: table vectors, directed stream/stall/reset sequences on
// a 16-bit instance, then randomized traffic on 16-, 13- and 2-bit instances
// compared against an arithmetic reference model.
`timescale 1ns/1ps
module tb_pipelined_prefix_adder;
    localparam int N_RAND     = 10000;
    localparam int RAND_LIMIT = 50000;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    typedef struct {
        longint unsigned sum;
        bit              cout;
        bit              ovf;
        int              cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    bit   start_rand = 1'b0;
    bit   rand_done [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic longint sext(input int w, input longint unsigned v);
        return (((v >> (w - 1)) & 64'd1) != 0) ? longint'(v) - (longint'(1) << w) : longint'(v);
    endfunction

    // Plain arithmetic: modulo sum, carry beyond bit w-1, signed range test.
    function automatic exp_t ref_model(input int w, input longint unsigned a, input longint unsigned b,
                                       input bit cin, input bit sub);
        exp_t            r;
        longint unsigned mask;
        longint unsigned be;
        longint unsigned full;
        longint          s;
        longint          hi;
        longint          lo;
        bit              ci;
        mask   = (64'd1 << w) - 64'd1;
        ci     = cin ^ sub;
        be     = sub ? (~b & mask) : (b & mask);
        full   = (a & mask) + be + 64'(ci);
        r.sum  = full & mask;
        r.cout = ((full >> w) & 64'd1) != 0;
        s      = sext(w, a & mask) + sext(w, be) + longint'(ci);
        hi     = (longint'(1) << (w - 1)) - 1;
        lo     = -(longint'(1) << (w - 1));
        r.ovf  = (s > hi) || (s < lo);
        r.cyc  = 0;
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Directed 16-bit instance
    // ------------------------------------------------------------------
    pipelined_prefix_adder_if #(.WIDTH(16)) d_if ();
    pipelined_prefix_adder #(.WIDTH(16)) u_dut16 (.clk(clk), .rst(rst), .bus(d_if));

    task automatic stream16(input string tag, input int n, input int s0, input int len);
        exp_t        q[$];
        exp_t        e;
        int          cyc;
        int          sent;
        int          got;
        int          prev_pop;
        int          gaps;
        bit          have;
        logic [17:0] held;
        cyc = 0; sent = 0; got = 0; prev_pop = -1; gaps = 0; have = 1'b0; held = '0;
        while ((sent < n || q.size() != 0) && cyc < 300) begin
            @(negedge clk);
            cyc++;
            d_if.out_ready = !(cyc >= s0 && cyc < s0 + len);
            if (!have && sent < n) begin
                d_if.in_a   = 16'($urandom());
                d_if.in_b   = 16'($urandom());
                d_if.in_cin = 1'($urandom_range(0, 1));
                d_if.in_sub = 1'($urandom_range(0, 1));
                have = 1'b1;
            end
            d_if.in_valid = have;
            #1;
            if (cyc >= s0 && cyc < s0 + len) begin
                check({tag, " in_ready_low"}, d_if.in_ready, 0);
                if (cyc == s0) held = {d_if.out_ovf, d_if.out_cout, d_if.out_sum};
                else check({tag, " held"}, {d_if.out_valid, d_if.out_ovf, d_if.out_cout, d_if.out_sum}, {1'b1, held});
            end
            if (len > 0 && cyc == s0 + len)
                check({tag, " accept_on_ready_rise"}, d_if.in_valid & d_if.in_ready, 1);
            if (d_if.out_valid && d_if.out_ready) begin
                if (q.size() == 0) begin
                    check({tag, " unexpected"}, d_if.out_valid, 0);
                end else begin
                    e = q.pop_front();
                    check({tag, " result"}, {d_if.out_ovf, d_if.out_cout, d_if.out_sum},
                          {e.ovf, e.cout, e.sum[15:0]});
                    if (prev_pop >= 0 && cyc != prev_pop + 1) gaps++;
                    prev_pop = cyc;
                    got++;
                end
            end
            if (d_if.in_valid && d_if.in_ready) begin
                q.push_back(ref_model(16, d_if.in_a, d_if.in_b, d_if.in_cin, d_if.in_sub));
                sent++;
                have = 1'b0;
            end
        end
        d_if.in_valid = 1'b0;
        check({tag, " count"}, got, n);
        if (len == 0) check({tag, " gaps"}, gaps, 0);
    endtask

    vec_t vecs [7];

    initial begin
        int lat;
        int stale;
        rst = 1'b1;
        d_if.in_valid = 1'b0; d_if.in_a = '0; d_if.in_b = '0;
        d_if.in_cin = 1'b0; d_if.in_sub = 1'b0; d_if.out_ready = 1'b1;

        vecs[0] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[1] = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        vecs[2] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[3] = '{16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0};
        vecs[4] = '{16'h1234, 16'h1234, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        vecs[5] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[6] = '{16'h5555, 16'hAAAA, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset out_valid", d_if.out_valid, 0);
        check("reset out_sum", d_if.out_sum, 0);
        check("reset out_cout", d_if.out_cout, 0);
        check("reset out_ovf", d_if.out_ovf, 0);
        check("reset in_ready", d_if.in_ready, 0);
        rst = 1'b0;
        #1;
        check("in_ready after reset", d_if.in_ready, 1);

        // Table vectors, one beat at a time, latency measured in edges
        foreach (vecs[v]) begin
            @(negedge clk);
            d_if.in_valid = 1'b1;  d_if.in_a = vecs[v].a; d_if.in_b = vecs[v].b;
            d_if.in_cin = vecs[v].cin; d_if.in_sub = vecs[v].sub; d_if.out_ready = 1'b1;
            @(negedge clk);
            d_if.in_valid = 1'b0;
            lat = 1;
            while (!d_if.out_valid && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            check($sformatf("vec%0d latency", v), lat, 6);
            check($sformatf("vec%0d sum", v), d_if.out_sum, vecs[v].sum);
            check($sformatf("vec%0d cout", v), d_if.out_cout, vecs[v].cout);
            check($sformatf("vec%0d ovf", v), d_if.out_ovf, vecs[v].ovf);
        end

        stream16("b2b", 20, 0, 0);
        stream16("stall", 12, 10, 5);

        // Reset with four beats in flight; a beat offered during reset is refused
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            d_if.out_ready = 1'b1; d_if.in_valid = 1'b1;
            d_if.in_a = 16'($urandom()); d_if.in_b = 16'($urandom());
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_reset in_ready", d_if.in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        d_if.in_valid = 1'b0;
        #1;
        check("mid_reset out_valid", d_if.out_valid, 0);
        check("mid_reset outputs", {d_if.out_ovf, d_if.out_cout, d_if.out_sum}, 0);
        stale = 0;
        repeat (15) begin
            @(negedge clk);
            #1;
            if (d_if.out_valid) stale++;
        end
        check("mid_reset no_stale", stale, 0);

        start_rand = 1'b1;
        wait (rand_done[0] && rand_done[1] && rand_done[2]);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Randomized instances
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < 3; gi++) begin : g_rand
        localparam int W   = (gi == 0) ? 16 : (gi == 1) ? 13 : 2;
        localparam int LAT = $clog2(W) + 2;

        pipelined_prefix_adder_if #(.WIDTH(W)) r_if ();
        pipelined_prefix_adder #(.WIDTH(W)) u_dut (.clk(clk), .rst(rst), .bus(r_if));

        initial begin
            exp_t         q[$];
            exp_t         e;
            int           cyc;
            int           sent;
            int           last_stall;
            bit           have;
            bit           prev_stall;
            logic [W+1:0] held;
            string        tag;
            cyc = 0; sent = 0; last_stall = -1; have = 1'b0; prev_stall = 1'b0; held = '0;
            rand_done[gi] = 1'b0;
            r_if.in_valid = 1'b0; r_if.in_a = '0; r_if.in_b = '0;
            r_if.in_cin = 1'b0; r_if.in_sub = 1'b0; r_if.out_ready = 1'b1;
            wait (start_rand);
            tag = $sformatf("rand_w%0d", W);
            while ((sent < N_RAND || q.size() != 0) && cyc < RAND_LIMIT) begin
                @(negedge clk);
                cyc++;
                if (prev_stall)
                    check({tag, " hold"}, {r_if.out_valid, r_if.out_ovf, r_if.out_cout, r_if.out_sum}, {1'b1, held});
                r_if.out_ready = ($urandom_range(0, 3) != 0);
                if (!have && sent < N_RAND) begin
                    r_if.in_a   = W'($urandom());
                    r_if.in_b   = W'($urandom());
                    r_if.in_cin = 1'($urandom_range(0, 1));
                    r_if.in_sub = 1'($urandom_range(0, 1));
                    have = 1'b1;
                end
                r_if.in_valid = have && ($urandom_range(0, 4) != 0);
                #1;
                if (r_if.out_valid && r_if.out_ready) begin
                    if (q.size() == 0) begin
                        check({tag, " unexpected"}, r_if.out_valid, 0);
                    end else begin
                        e = q.pop_front();
                        check({tag, " result"}, {r_if.out_ovf, r_if.out_cout, r_if.out_sum},
                              {e.ovf, e.cout, e.sum[W-1:0]});
                        if (last_stall < e.cyc) check({tag, " latency"}, cyc - e.cyc, LAT);
                    end
                end
                prev_stall = r_if.out_valid && !r_if.out_ready;
                if (prev_stall) begin
                    last_stall = cyc;
                    held = {r_if.out_ovf, r_if.out_cout, r_if.out_sum};
                end
                if (r_if.in_valid && r_if.in_ready) begin
                    e = ref_model(W, r_if.in_a, r_if.in_b, r_if.in_cin, r_if.in_sub);
                    e.cyc = cyc;
                    q.push_back(e);
                    sent++;
                    have = 1'b0;
                end
            end
            r_if.in_valid = 1'b0;
            check({tag, " drained"}, q.size() + (N_RAND - sent), 0);
            rand_done[gi] = 1'b1;
        end
    end
endmodule
